// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage RV32I pipeline: load-use bubbles, branch flushes,
// data-memory freezes and a sticky memory-timeout trap. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned WAIT_CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        IF_ID_UsesRs1,
  input  logic        IF_ID_UsesRs2,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        BranchTaken,
  input  logic        DmemReq,
  input  logic        DmemReady,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Write,
  output logic        MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] LoadUseCnt,
  output logic [31:0] MemWaitCnt,
  output logic [31:0] FlushCnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TRAP     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                  r_pend_flush;
  logic                  w_pend_flush_nxt;
  logic                  r_mem_timeout;
  logic                  w_mem_timeout_nxt;

  logic w_load_use;
  logic w_br;
  logic w_freeze;
  logic w_decide;
  logic w_rule_br;
  logic w_rule_lu;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((IF_ID_UsesRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                       (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));
  assign w_br       = BranchTaken | r_pend_flush;

  // State, wait counter and pending-flush bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_pend_flush  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_pend_flush  <= w_pend_flush_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  // Next state; w_decide marks cycles where the branch/load-use priority applies
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_pend_flush_nxt  = r_pend_flush;
    w_mem_timeout_nxt = r_mem_timeout;
    w_freeze          = 1'b0;
    w_decide          = 1'b0;
    w_rule_br         = 1'b0;
    w_rule_lu         = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (DmemReq && !DmemReady) begin
          w_freeze         = 1'b1;
          w_state_nxt      = ST_MEM_WAIT;
          w_wait_cnt_nxt   = WAIT_CNT_W'(1);
          w_pend_flush_nxt = w_br;
        end else begin
          w_decide = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!DmemReady) begin
          w_freeze         = 1'b1;
          w_pend_flush_nxt = r_pend_flush | BranchTaken;
          if (r_wait_cnt == TIMEOUT_LAST) begin
            w_state_nxt       = ST_TRAP;
            w_mem_timeout_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
          end
        end else begin
          w_decide       = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_TRAP: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    w_rule_br = w_decide && w_br;
    w_rule_lu = w_decide && !w_br && w_load_use;
    // A flush discards any load-use in ID and consumes the pending redirect
    if (w_rule_br) begin
      w_pend_flush_nxt = 1'b0;
    end
  end

  // Reset holds every stage and injects bubbles
  assign PCWrite      = rst_n && !w_freeze && !w_rule_lu;
  assign IF_ID_Write  = rst_n && !w_freeze && !w_rule_lu;
  assign IF_ID_Flush  = !rst_n || w_rule_br;
  assign ID_EX_Write  = rst_n && !w_freeze;
  assign ID_EX_Flush  = !rst_n || w_rule_br || w_rule_lu;
  assign EX_MEM_Write = rst_n && !w_freeze;
  assign MemTimeout   = rst_n && r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic        w_wait_freeze;
  logic [31:0] r_load_use_cnt;
  logic [31:0] r_mem_wait_cnt;
  logic [31:0] r_flush_cnt;

  assign w_wait_freeze = (r_state == ST_MEM_WAIT) && !DmemReady;

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_use_cnt <= '0;
      r_mem_wait_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_rule_lu)     r_load_use_cnt <= r_load_use_cnt + 32'd1;
      if (w_wait_freeze) r_mem_wait_cnt <= r_mem_wait_cnt + 32'd1;
      if (w_rule_br)     r_flush_cnt    <= r_flush_cnt + 32'd1;
    end
  end

  assign LoadUseCnt = r_load_use_cnt;
  assign MemWaitCnt = r_mem_wait_cnt;
  assign FlushCnt   = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (TIMEOUT_CYCLES=4) with a cycle-level reference model.
module tb_hazard_stall_unit;

  localparam int unsigned TO = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, req, rdy;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, tmo;

  int checks = 0;
  int errors = 0;

  // Reference model state: trapped, inside a memory wait, pending redirect, not-ready run length
  logic m_trap, m_waiting, m_pend;
  int   m_nr;

  hazard_stall_unit #(.TIMEOUT_CYCLES(TO), .WAIT_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
    .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .BranchTaken(br),
    .DmemReq(req), .DmemReady(rdy),
    .PCWrite(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f),
    .ID_EX_Write(idex_w), .ID_EX_Flush(idex_f), .EX_MEM_Write(exmem_w),
    .MemTimeout(tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output vector order: PCWrite IF_ID_Write IF_ID_Flush ID_EX_Write ID_EX_Flush EX_MEM_Write MemTimeout
  function automatic logic [6:0] dut_vec();
    return {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, tmo};
  endfunction

  function automatic logic model_freeze();
    return m_waiting ? !rdy : (req && !rdy);
  endfunction

  function automatic logic [6:0] model_vec();
    logic lu;
    lu = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (!rst_n)              return 7'b0010100;
    if (m_trap)              return 7'b0000001;
    if (model_freeze())      return 7'b0000000;
    if (br || m_pend)        return 7'b1111110;
    if (lu)                  return 7'b0001110;
    return 7'b1101010;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_trap = 1'b0; m_waiting = 1'b0; m_pend = 1'b0; m_nr = 0;
    end else if (!m_trap) begin
      if (model_freeze()) begin
        m_pend    = m_pend | br;
        m_waiting = 1'b1;
        m_nr      = m_nr + 1;
        if (m_nr == TO) m_trap = 1'b1;
      end else begin
        m_waiting = 1'b0; m_pend = 1'b0; m_nr = 0;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    checks = checks + 1;
    if (dut_vec() !== model_vec()) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t got %b exp %b", $time, dut_vec(), model_vec());
    end
  end

  task automatic lit(input string name, input logic [6:0] exp);
    checks = checks + 1;
    if (dut_vec() !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b exp %b", name, dut_vec(), exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic iu1, input logic iu2,
                       input logic imr, input logic [4:0] ird, input logic ibr,
                       input logic ireq, input logic irdy);
    rs1 = a1; rs2 = a2; u1 = iu1; u2 = iu2; mr = imr; rd = ird; br = ibr; req = ireq; rdy = irdy;
  endtask

  // Apply one cycle of inputs, check a literal expectation, advance past the next edge
  task automatic cyc(input string name, input logic [6:0] exp,
                     input logic [4:0] a1, input logic [4:0] a2, input logic iu1, input logic iu2,
                     input logic imr, input logic [4:0] ird, input logic ibr,
                     input logic ireq, input logic irdy);
    drive(a1, a2, iu1, iu2, imr, ird, ibr, ireq, irdy);
    #2;
    lit(name, exp);
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] RUNV = 7'b1101010;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] FLSH = 7'b1111110;
  localparam logic [6:0] LUV  = 7'b0001110;
  localparam logic [6:0] TRP  = 7'b0000001;
  localparam logic [6:0] RSTV = 7'b0010100;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    lit("reset_outputs", RSTV);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use: one bubble, then normal flow once the load leaves EX
    cyc("lu_rs1",       LUV,  5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("lu_after",     RUNV, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    cyc("lu_rd_x0",     RUNV, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2_unused",RUNV, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2",       LUV,  5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2_after", RUNV, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);

    // Three-cycle memory freeze, release, then a zero-wait access
    cyc("mw_frz0",      FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("mw_frz1",      FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("mw_frz2",      FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("mw_release",   RUNV, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("mw_zero_wait", RUNV, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Branch resolved during the freeze flushes once on release
    cyc("bw_frz0",      FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("bw_frz_br",    FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("bw_frz2",      FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("bw_release",   FLSH, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("bw_once",      RUNV, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Branch entering the freeze is held and applied on release
    cyc("be_entry",     FRZ,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("be_release",   FLSH, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Branch beats load-use; load-use still applies on a clean release
    cyc("br_over_lu",   FLSH, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc("lw_frz",       FRZ,  5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    cyc("lw_release_lu",LUV,  5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
    cyc("lw_after",     RUNV, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

    // Reset during a wait drops the pending redirect
    cyc("rw_frz_br",    FRZ,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    lit("rw_in_reset", RSTV);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("rw_no_flush",  RUNV, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Timeout after four not-ready cycles; trap ignores later readiness
    for (int i = 0; i < int'(TO); i++)
      cyc("to_freeze",  FRZ,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("to_trap",      TRP,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("to_trap_rdy",  TRP,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    cyc("to_trap_idle", TRP,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset takes effect immediately out of the trap
    #1;
    rst_n = 1'b0;
    #1;
    lit("trap_async_rst", RSTV);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post_trap_run", RUNV, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("post_trap_lu",  LUV,  5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
